// File: rtl/sd_cmd_rsp_receiver_pkg.sv
// Shared SD command-path definitions: receiver FSM encoding, response framing sizes,
// payload widths and the default NCR window.
package sd_cmd_rsp_receiver_pkg;

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        WAIT_START = 2'd1,
        RECV       = 2'd2,
        DONE       = 2'd3
    } rsp_state_e;

    localparam int RSP_LEN_SHORT   = 48;
    localparam int RSP_LEN_LONG    = 136;
    localparam int PAY_W_SHORT     = 38;
    localparam int PAY_W_LONG      = 120;
    localparam int CRC_W           = 7;
    localparam int TIMEOUT_DEFAULT = 64;

endpackage

// File: rtl/sd_crc7.sv
// CRC7 (x^7 + x^3 + 1) accumulator for the SD CMD line. RST is a synchronous clear;
// SH shifts the remainder out MSB-first when not accumulating.
module sd_crc7 (
    input  logic       CLK,
    input  logic       RST,
    input  logic       EN,
    input  logic       SH,
    input  logic       DAT,
    output logic [6:0] CRC
);

    logic [6:0] crc_q;
    logic       fb;

    assign fb  = DAT ^ crc_q[6];
    assign CRC = crc_q;

    always_ff @(negedge CLK) begin
        if (RST) begin
            crc_q <= '0;
        end else if (EN) begin
            crc_q <= {crc_q[5:0], 1'b0} ^ (fb ? 7'h09 : 7'h00);
        end else if (SH) begin
            crc_q <= {crc_q[5:0], 1'b0};
        end
    end

endmodule

// File: rtl/sd_cmd_rsp_receiver.sv
// SD CMD-line response receiver: arms after a command, finds the start bit, deserialises and
// checks the response. Defining SD_RSP_R2_EN adds 136-bit R2 (CID/CSD) reception.
module sd_cmd_rsp_receiver
    import sd_cmd_rsp_receiver_pkg::*;
#(
    parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
    input  logic                   CLK,
    input  logic                   RST,
    input  logic                   I_ARM,
    input  logic                   I_RSP_EN,
    input  logic                   I_NOCRC,
`ifdef SD_RSP_R2_EN
    input  logic                   I_LONG,
    output logic [PAY_W_LONG-1:0]  O_RSP_L,
`endif
    input  logic                   I_CMD,
    output logic                   O_BUSY,
    output logic                   O_STB,
    input  logic                   I_ACK,
    output logic [PAY_W_SHORT-1:0] O_RSP,
    output logic                   O_TIMEOUT,
    output logic                   O_CRC_ERR,
    output logic                   O_DIR_ERR,
    output logic                   O_END_ERR,
    output logic [1:0]             O_DBG_STATE
);

    // Handshake: O_STB and the result are held stable until the edge that samples
    // I_ACK high while O_STB is high; that edge drops O_STB and O_BUSY together.

`ifdef SD_RSP_R2_EN
    localparam int SH_W  = RSP_LEN_LONG - 2;
    localparam int CNT_W = 8;
    localparam logic [CNT_W-1:0] CNT_LONG  = CNT_W'(RSP_LEN_LONG - 2);
    localparam logic [CNT_W-1:0] CRC_HI_L  = CNT_W'(PAY_W_LONG + CRC_W + 1);
    localparam int               PAY_HI_L  = CRC_W + PAY_W_LONG - 1;
`else
    localparam int SH_W  = RSP_LEN_SHORT - 2;
    localparam int CNT_W = 6;
`endif
    localparam int               TMO_W     = 7;
    localparam logic [TMO_W-1:0] TMO_LOAD  = TMO_W'(TIMEOUT - 1);
    localparam logic [CNT_W-1:0] CNT_SHORT = CNT_W'(RSP_LEN_SHORT - 2);
    localparam logic [CNT_W-1:0] CRC_LO    = CNT_W'(CRC_W);
    localparam int               PAY_HI_S  = CRC_W + PAY_W_SHORT - 1;

    rsp_state_e             state_q;
    logic [TMO_W-1:0]       tmo_cnt_q;
    logic [CNT_W-1:0]       bit_cnt_q;
    logic [SH_W-1:0]        shreg_q;
    logic                   nocrc_q;
    logic                   end_bit_q;
    logic                   tmo_hit_q;
    logic                   stb_q;
    logic                   busy_q;
    logic                   timeout_q;
    logic                   crc_err_q;
    logic                   dir_err_q;
    logic                   end_err_q;
    logic [PAY_W_SHORT-1:0] rsp_q;

    logic [CNT_W-1:0]       bit_cnt_load;
    logic                   crc_win_hi;
    logic                   crc_en;
    logic                   crc_clr;
    logic [CRC_W-1:0]       crc_calc;
    logic                   dir_bit;

`ifdef SD_RSP_R2_EN
    logic                   long_q;
    logic [PAY_W_LONG-1:0]  rsp_l_q;
    logic                   rsv_unused;

    assign bit_cnt_load = long_q ? CNT_LONG : CNT_SHORT;
    // R2 checks CRC only over CID/CSD[127:8]; transmission and reserved bits are excluded.
    assign crc_win_hi   = !long_q || (bit_cnt_q < CRC_HI_L);
    assign dir_bit      = long_q ? shreg_q[SH_W-1] : shreg_q[RSP_LEN_SHORT-3];
    assign rsv_unused   = ^shreg_q[SH_W-2:PAY_HI_L+1];
    assign O_RSP_L      = rsp_l_q;
`else
    assign bit_cnt_load = CNT_SHORT;
    assign crc_win_hi   = 1'b1;
    assign dir_bit      = shreg_q[SH_W-1];
`endif

    // The start bit is CRC bit 0, but a zero bit into a cleared CRC leaves it zero, so
    // holding the CRC cleared outside RECV is equivalent to accumulating it.
    assign crc_clr = (state_q != RECV);
    assign crc_en  = (state_q == RECV) && (bit_cnt_q > CRC_LO) && crc_win_hi;

    sd_crc7 u_crc7 (
        .CLK (CLK),
        .RST (crc_clr),
        .EN  (crc_en),
        .SH  (1'b0),
        .DAT (I_CMD),
        .CRC (crc_calc)
    );

    always_ff @(negedge CLK or posedge RST) begin
        if (RST) begin
            state_q   <= IDLE;
            tmo_cnt_q <= '0;
            bit_cnt_q <= '0;
            shreg_q   <= '0;
            nocrc_q   <= 1'b0;
            end_bit_q <= 1'b0;
            tmo_hit_q <= 1'b0;
            stb_q     <= 1'b0;
            busy_q    <= 1'b0;
            timeout_q <= 1'b0;
            crc_err_q <= 1'b0;
            dir_err_q <= 1'b0;
            end_err_q <= 1'b0;
            rsp_q     <= '0;
`ifdef SD_RSP_R2_EN
            long_q    <= 1'b0;
            rsp_l_q   <= '0;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    if (I_ARM && I_RSP_EN) begin
                        state_q   <= WAIT_START;
                        busy_q    <= 1'b1;
                        nocrc_q   <= I_NOCRC;
                        tmo_cnt_q <= TMO_LOAD;
                        tmo_hit_q <= 1'b0;
                        shreg_q   <= '0;
`ifdef SD_RSP_R2_EN
                        long_q    <= I_LONG;
`endif
                    end
                end
                WAIT_START: begin
                    if (!I_CMD) begin
                        state_q   <= RECV;
                        bit_cnt_q <= bit_cnt_load;
                    end else if (tmo_cnt_q == '0) begin
                        state_q   <= DONE;
                        tmo_hit_q <= 1'b1;
                    end else begin
                        tmo_cnt_q <= tmo_cnt_q - 1'b1;
                    end
                end
                RECV: begin
                    if (bit_cnt_q == '0) begin
                        end_bit_q <= I_CMD;
                        state_q   <= DONE;
                    end else begin
                        shreg_q   <= {shreg_q[SH_W-2:0], I_CMD};
                        bit_cnt_q <= bit_cnt_q - 1'b1;
                    end
                end
                DONE: begin
                    // First DONE edge publishes the result; later edges wait for I_ACK.
                    if (!stb_q) begin
                        stb_q <= 1'b1;
                        if (tmo_hit_q) begin
                            timeout_q <= 1'b1;
                        end else begin
                            dir_err_q <= dir_bit;
                            end_err_q <= !end_bit_q;
                            crc_err_q <= !nocrc_q && (shreg_q[CRC_W-1:0] != crc_calc);
`ifdef SD_RSP_R2_EN
                            rsp_q     <= long_q ? '0 : shreg_q[PAY_HI_S:CRC_W];
                            rsp_l_q   <= long_q ? shreg_q[PAY_HI_L:CRC_W] : '0;
`else
                            rsp_q     <= shreg_q[PAY_HI_S:CRC_W];
`endif
                        end
                    end else if (I_ACK) begin
                        state_q   <= IDLE;
                        stb_q     <= 1'b0;
                        busy_q    <= 1'b0;
                        timeout_q <= 1'b0;
                        crc_err_q <= 1'b0;
                        dir_err_q <= 1'b0;
                        end_err_q <= 1'b0;
                        rsp_q     <= '0;
`ifdef SD_RSP_R2_EN
                        rsp_l_q   <= '0;
`endif
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign O_BUSY      = busy_q;
    assign O_STB       = stb_q;
    assign O_RSP       = rsp_q;
    assign O_TIMEOUT   = timeout_q;
    assign O_CRC_ERR   = crc_err_q;
    assign O_DIR_ERR   = dir_err_q;
    assign O_END_ERR   = end_err_q;
    assign O_DBG_STATE = state_q;

endmodule

// File: tb/tb_sd_cmd_rsp_receiver.sv
// Bench for sd_cmd_rsp_receiver: directed response table, randomized responses against a
// frame-level reference model, and hand-written handshake, arm and reset sequences.
`timescale 1ns/1ps
module tb_sd_cmd_rsp_receiver;

    localparam int TMO = 64;

    typedef struct {
        logic [47:0] frame;
        bit          nc;
        int          idle;
        int          hold;
        logic [41:0] exp_res;   // {timeout, crc_err, dir_err, end_err, rsp[37:0]}
    } vec_t;

    // ---------------- clock / reset ----------------
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        arm = 1'b0;
    logic        rsp_en = 1'b0;
    logic        nocrc = 1'b0;
    logic        cmd = 1'b1;
    logic        ack = 1'b0;
    logic        busy, stb, timeout, crc_err, dir_err, end_err;
    logic [37:0] rsp;
    logic [1:0]  dbg_state;

    always #5 clk = ~clk;

    sd_cmd_rsp_receiver #(.TIMEOUT(TMO)) dut (
        .CLK         (clk),
        .RST         (rst),
        .I_ARM       (arm),
        .I_RSP_EN    (rsp_en),
        .I_NOCRC     (nocrc),
        .I_CMD       (cmd),
        .O_BUSY      (busy),
        .O_STB       (stb),
        .I_ACK       (ack),
        .O_RSP       (rsp),
        .O_TIMEOUT   (timeout),
        .O_CRC_ERR   (crc_err),
        .O_DIR_ERR   (dir_err),
        .O_END_ERR   (end_err),
        .O_DBG_STATE (dbg_state)
    );

    int          n_cmp = 0;
    int          n_bad = 0;
    logic [41:0] exp_q[$];
    vec_t        tbl[8];

    // ---------------- reference model ----------------
    // CRC7 as the remainder of M(x)*x^7 divided by x^7 + x^3 + 1.
    function automatic logic [6:0] crc7_ref(input logic [39:0] msg);
        logic [46:0] rem;
        rem = {msg, 7'h00};
        for (int i = 46; i >= 7; i--) begin
            if (rem[i]) rem[i -: 8] = rem[i -: 8] ^ 8'h89;
        end
        return rem[6:0];
    endfunction

    function automatic logic [41:0] model_res(input logic [47:0] f, input bit nc, input int idle);
        if (idle >= TMO) return {1'b1, 41'h0};
        return {1'b0, (!nc && (crc7_ref(f[47:8]) != f[7:1])), f[46], !f[0], f[45:8]};
    endfunction

    function automatic int model_lat(input int idle);
        return (idle >= TMO) ? TMO + 1 : idle + 49;
    endfunction

    function automatic logic [41:0] cur_res();
        return {timeout, crc_err, dir_err, end_err, rsp};
    endfunction

    // ---------------- driver / checker tasks ----------------
    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic check_idle_outputs(input string tag);
        check($sformatf("%s_busy", tag), busy, 0);
        check($sformatf("%s_stb", tag), stb, 0);
        check($sformatf("%s_result", tag), cur_res(), 0);
    endtask

    task automatic run_txn(input logic [47:0] f, input bit nc, input int idle, input bit ack_noise,
                           input int hold, input logic [41:0] exp_res, input string tag);
        int          lat;
        int          n;
        logic [41:0] exp;
        exp_q.push_back(exp_res);
        arm = 1'b1; rsp_en = 1'b1; nocrc = nc; cmd = 1'b1; ack = 1'b0;
        tick();
        lat = 0;
        arm = 1'b0; nocrc = ~nc;
        check($sformatf("%s_busy_arm", tag), busy, 1);
        for (int i = 0; i < idle && i < TMO; i++) begin
            ack = ack_noise ? 1'($urandom_range(0, 1)) : 1'b0;
            tick(); lat++;
        end
        if (idle < TMO) begin
            for (int i = 47; i >= 0; i--) begin
                cmd = f[i];
                ack = ack_noise ? 1'($urandom_range(0, 1)) : 1'b0;
                tick(); lat++;
            end
        end
        cmd = 1'b1; ack = 1'b0;
        check($sformatf("%s_busy_mid", tag), busy, 1);
        n = 0;
        while (stb !== 1'b1 && n < 200) begin
            tick(); lat++; n++;
        end
        check($sformatf("%s_latency", tag), lat, model_lat(idle));
        exp = exp_q.pop_front();
        check($sformatf("%s_result", tag), cur_res(), exp);
        for (int i = 0; i < hold; i++) begin
            arm = (i == hold / 2); rsp_en = 1'b1;
            cmd = 1'($urandom_range(0, 1));
            tick();
            check($sformatf("%s_hold_stb", tag), stb, 1);
            check($sformatf("%s_hold_res", tag), cur_res(), exp);
        end
        arm = 1'b0; cmd = 1'b1;
        ack = 1'b1;
        tick();
        ack = 1'b0;
        check_idle_outputs($sformatf("%s_after_ack", tag));
    endtask

    task automatic set_vec(input int i, input logic [47:0] f, input bit nc, input int idle,
                           input int hold, input logic [41:0] exp_res);
        tbl[i].frame   = f;
        tbl[i].nc      = nc;
        tbl[i].idle    = idle;
        tbl[i].hold    = hold;
        tbl[i].exp_res = exp_res;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    // ---------------- test sequence ----------------
    initial begin
        logic [39:0] r1_head;
        logic [39:0] r1b_head;
        logic [47:0] r1_frame;
        logic [47:0] f;
        logic [39:0] f40;
        logic [6:0]  c;
        logic        nc;
        int          idle;
        int          r;

        r1_head  = 40'h11_0000_0900;
        r1b_head = 40'h37_0000_0120;
        r1_frame = {r1_head, crc7_ref(r1_head), 1'b1};

        repeat (3) @(negedge clk);
        #1;
        check_idle_outputs("reset_held");
        check("reset_timeout", timeout, 0);
        rst = 1'b0;
        tick();
        check_idle_outputs("reset_release");

        // Arm without an expected response must be ignored.
        arm = 1'b1; rsp_en = 1'b0;
        tick();
        arm = 1'b0;
        check("noresp_busy", busy, 0);
        repeat (3) tick();
        check_idle_outputs("noresp_idle");

        // ACK outside DONE is ignored.
        ack = 1'b1;
        tick();
        ack = 1'b0;
        check_idle_outputs("stray_ack");

        set_vec(0, r1_frame, 1'b0, 5, 20, {4'b0000, 38'h11_00000900});
        set_vec(1, 48'h40_0000_0000_95, 1'b0, 3, 1, {4'b0010, 38'h0});
        set_vec(2, 48'h40_0000_0000_97, 1'b0, 0, 0, {4'b0110, 38'h0});
        set_vec(3, 48'h3F_80FF_8000_FF, 1'b1, 10, 2, {4'b0000, 38'h3F_80FF8000});
        set_vec(4, {r1_head, crc7_ref(r1_head), 1'b0}, 1'b0, 7, 0, {4'b0001, 38'h11_00000900});
        set_vec(5, r1_frame, 1'b0, TMO, 3, {4'b1000, 38'h0});
        set_vec(6, r1_frame, 1'b0, TMO - 1, 0, {4'b0000, 38'h11_00000900});
        set_vec(7, {r1b_head, crc7_ref(r1b_head), 1'b1}, 1'b0, 2, 1, {4'b0000, 38'h37_00000120});

        for (int i = 0; i < 8; i++) begin
            run_txn(tbl[i].frame, tbl[i].nc, tbl[i].idle, 1'b0, tbl[i].hold, tbl[i].exp_res,
                    $sformatf("vec%0d", i));
        end

        // Reset during RECV after 20 bits following the start bit.
        arm = 1'b1; rsp_en = 1'b1; nocrc = 1'b0; cmd = 1'b1;
        tick();
        arm = 1'b0;
        repeat (2) tick();
        for (int i = 47; i >= 27; i--) begin
            cmd = r1_frame[i];
            tick();
        end
        rst = 1'b1;
        #2;
        check_idle_outputs("rst_mid_recv");
        rst = 1'b0;
        cmd = 1'b1;
        tick();
        check_idle_outputs("rst_mid_recv_after");
        repeat (30) tick();
        check_idle_outputs("rst_mid_recv_discard");
        run_txn(r1_frame, 1'b0, 4, 1'b0, 0, {4'b0000, 38'h11_00000900}, "post_rst");

        // Randomized responses against the reference model.
        for (int k = 0; k < 30; k++) begin
            f40 = {1'b0, ($urandom_range(0, 7) == 0), 6'($urandom_range(0, 63)), 32'($urandom)};
            c   = crc7_ref(f40);
            if ($urandom_range(0, 3) == 0) c = c ^ 7'($urandom_range(1, 127));
            f   = {f40, c, ($urandom_range(0, 7) != 0)};
            nc  = ($urandom_range(0, 3) == 0);
            r   = $urandom_range(0, 9);
            if (r == 0)      idle = $urandom_range(TMO, TMO + 3);
            else if (r == 1) idle = TMO - 1;
            else             idle = $urandom_range(0, 15);
            run_txn(f, nc, idle, 1'b1, $urandom_range(0, 3), model_res(f, nc, idle),
                    $sformatf("rnd%0d", k));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/sd_cmd_rsp_receiver.md
# sd_cmd_rsp_receiver

- Receives the card's response on the SD CMD line after the command formatter has shifted out a command.
- Arms on the formatter's last-bit flag, then searches for the response start bit within a bounded window.
- Deserialises the 48-bit response, checks transmission bit, CRC7 and end bit, and presents the payload to the command controller with an STB/ACK handshake.

## Interface
- `TIMEOUT`, default 64: max CLK cycles from arm to start bit (NCR).
- `CLK`  in  1  bit clock; CMD sampled and all state updated on negedge, same edge as the formatter.
- `RST`  in  1  reset, asynchronous, active-high.
- `I_ARM`  in  1  one-cycle pulse; connect to formatter `O_BIT_LST`.
- `I_RSP_EN`  in  1  response expected for this command; sampled with `I_ARM`.
- `I_NOCRC`  in  1  skip CRC check (R3); sampled with `I_ARM`.
- `I_CMD`  in  1  CMD line input, already synchronised.
- `O_BUSY`  out  1  high from accepted arm until `O_STB`/`I_ACK` completes.
- `O_STB`  out  1  result valid; held until `I_ACK`.
- `I_ACK`  in  1  consumer accepts result.
- `O_RSP`  out  38  {index[5:0], arg[31:0]}.
- `O_TIMEOUT`  out  1  no start bit within `TIMEOUT`.
- `O_CRC_ERR`  out  1  CRC7 mismatch.
- `O_DIR_ERR`  out  1  transmission bit was 1.
- `O_END_ERR`  out  1  end bit was 0.

## Operation
- States: `IDLE`, `WAIT_START`, `RECV`, `DONE`.
- `IDLE`:
  - `I_ARM & I_RSP_EN` -> `WAIT_START`; latch `I_NOCRC`; load the timeout counter with `TIMEOUT-1`; clear CRC.
  - `I_ARM & !I_RSP_EN` is ignored.
- `WAIT_START`:
  - `I_CMD==0` -> `RECV`; load the bit counter with 46. The start bit is CRC bit 0.
  - Otherwise, if the timeout counter reaches 0 -> `DONE` with `O_TIMEOUT=1` and `O_RSP=0`.
  - Otherwise decrement the counter.
- `RECV`:
  - Shift `I_CMD` into a 46-bit register MSB-first and decrement the bit counter.
  - CRC is enabled for the first 39 bits after the start bit: the transmission bit plus the 38 payload bits.
  - The next 7 bits are the received CRC; the final bit is the end bit.
  - On the end bit -> `DONE`, registering all error flags.
- `DONE`: `O_STB=1`; on `I_ACK` -> `IDLE`, deasserting `O_STB` and clearing all flags.
- `O_CRC_ERR` is forced to 0 when `I_NOCRC` was latched.
- Flags are independent; several may be set at once.
- `I_ARM` outside `IDLE` is ignored and does not restart the window.
- Bit counter is 6-bit, timeout counter is 7-bit. Both saturate at 0, with no wrap.

## Timing
- Reset values:
  - `O_STB`, `O_BUSY`, all error flags: 0.
  - `O_RSP`: 0.
  - State: `IDLE`.
- `O_BUSY` rises on the edge that samples `I_ARM`.
- The first start-bit sample is the edge after the arm.
- `O_STB` and the final flags appear on the edge after the end bit is sampled: 48 edges after the start-bit edge.
- Timeout:
  - A start bit on the `TIMEOUT`-th edge after arm is accepted.
  - With no start bit, `O_STB` with `O_TIMEOUT` asserts on the following edge.
- `I_ACK` sampled high in `DONE`: `O_STB` and `O_BUSY` are low the next edge.
- An `I_ACK` while not in `DONE` has no effect.
- The earliest re-arm is the edge after `O_STB` falls.
- Reset mid-`RECV`: immediate return to `IDLE`, all outputs 0, partial data discarded.

## Configuration
- `SD_RSP_R2_EN`:
  - Defined: adds input `I_LONG` (sampled with `I_ARM`) and output `O_RSP_L[119:0]`.
  - With `I_LONG=1`, the bit counter loads 134 (widened to 8 bits) for the 136-bit R2 response.
  - `O_RSP_L` = CID/CSD[127:8]; CRC7 is computed over those 120 bits and compared with CID/CSD[7:1].
  - The 6 reserved bits are not checked.
  - `O_RSP` is 0 for R2.
- Undefined: 48-bit responses only; no `I_LONG` or `O_RSP_L` ports.

## Structure
- Shared SD package holds:
  - state encoding;
  - response lengths (48, 136);
  - payload widths (38, 120);
  - the default `TIMEOUT`.
- Sub-module: reuse `sd_crc7`.
  - `SH` tied 0.
  - `RST` driven while not in `RECV`.
  - `EN` during the CRC-covered bits.

## Test plan
- Valid R1:
  - Stimulus: arm, 5 idle-high cycles, then bytes `0x11 0x00 0x00 0x09 0x00` with the correct CRC byte from the bench model.
  - Required: `O_STB=1`, `O_RSP=0x11_00000900`, all flags 0.
- Direction and CRC errors:
  - Stimulus: stream `0x40 00 00 00 00 95`.
  - Required: `O_DIR_ERR=1`, `O_CRC_ERR=0`, `O_END_ERR=0`, `O_RSP=0`.
  - Stimulus: the same stream with last byte `0x97`.
  - Required: additionally `O_CRC_ERR=1`.
- Timeout:
  - Stimulus: arm with CMD held high.
  - Required: `O_STB` with `O_TIMEOUT=1` exactly 65 edges after arm. A start bit on edge 64 is received normally.
- Handshake and arm rules:
  - Hold `I_ACK=0` for 20 cycles: `O_STB`/`O_RSP` stable.
  - `I_ARM` pulsed in `DONE`: ignored.
  - `I_ARM` with `I_RSP_EN=0`: `O_BUSY` stays 0.
- R3 and end bit:
  - Stimulus: `I_NOCRC=1` with CRC field `0x7F`.
  - Required: `O_CRC_ERR=0`.
  - Stimulus: end bit 0.
  - Required: `O_END_ERR=1`.
- Reset:
  - Stimulus: `RST` pulsed at bit 20 of `RECV`.
  - Required: all outputs 0; a following valid response is received correctly.
